// File: rtl/mc_control_p.sv
// Multi-cycle MIPS-style main controller: sequences fetch/decode/execute/memory/writeback
// and decodes per-state datapath controls combinationally from the state register.
module mc_control_p #(
  parameter int              OP_W          = 6,
  parameter logic [OP_W-1:0] OP_RTYPE      = 6'h00,
  parameter logic [OP_W-1:0] OP_LW         = 6'h23,
  parameter logic [OP_W-1:0] OP_SW         = 6'h2B,
  parameter logic [OP_W-1:0] OP_BEQ        = 6'h04,
  parameter logic [OP_W-1:0] OP_ADDI       = 6'h08,
  parameter logic [OP_W-1:0] OP_J          = 6'h02,
  parameter int              USE_MEM_READY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            RegDst,
  output logic            ALUSrcA,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
  output logic            PCWrite,
  output logic            IorD,
  output logic            IRWrite,
  output logic [1:0]      ALUOp,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSource,
  output logic            illegal_op,
  output logic [3:0]      state_dbg
);

  // state | meaning
  // 0  IFETCH   | fetch instruction, PC+4, wait on memory
  // 1  ID       | decode, branch target into ALUOut
  // 2  EX_R     | R-type ALU operation
  // 3  WB_R     | R-type writeback to rd
  // 4  EX_B     | BEQ compare and conditional PC update
  // 5  EX_I     | ADDI add immediate
  // 6  WB_I     | ADDI writeback to rt
  // 7  MEM_ADDR | LW/SW effective address
  // 8  MEM_RD   | LW data read, wait on memory
  // 9  MEM_WB   | LW writeback to rt
  // 10 MEM_WR   | SW data write, wait on memory
  // 11 EX_J     | jump target into PC
  localparam logic [3:0] S_IFETCH   = 4'd0;
  localparam logic [3:0] S_ID       = 4'd1;
  localparam logic [3:0] S_EX_R     = 4'd2;
  localparam logic [3:0] S_WB_R     = 4'd3;
  localparam logic [3:0] S_EX_B     = 4'd4;
  localparam logic [3:0] S_EX_I     = 4'd5;
  localparam logic [3:0] S_WB_I     = 4'd6;
  localparam logic [3:0] S_MEM_ADDR = 4'd7;
  localparam logic [3:0] S_MEM_RD   = 4'd8;
  localparam logic [3:0] S_MEM_WB   = 4'd9;
  localparam logic [3:0] S_MEM_WR   = 4'd10;
  localparam logic [3:0] S_EX_J     = 4'd11;

  logic [3:0] state_q, state_d;
  logic       rdy;

  assign rdy       = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IFETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IFETCH;
    case (state_q)
      S_IFETCH: state_d = rdy ? S_ID : S_IFETCH;
      S_ID: begin
        if      (opcode == OP_RTYPE)                     state_d = S_EX_R;
        else if (opcode == OP_BEQ)                       state_d = S_EX_B;
        else if (opcode == OP_ADDI)                      state_d = S_EX_I;
        else if (opcode == OP_LW || opcode == OP_SW)     state_d = S_MEM_ADDR;
        else if (opcode == OP_J)                         state_d = S_EX_J;
        else                                             state_d = S_IFETCH;
      end
      S_EX_R:     state_d = S_WB_R;
      S_EX_I:     state_d = S_WB_I;
      // IR holds the opcode, so it is still valid here
      S_MEM_ADDR: begin
        if      (opcode == OP_LW) state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_IFETCH;
      end
      S_MEM_RD:   state_d = rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = rdy ? S_IFETCH : S_MEM_WR;
      default:    state_d = S_IFETCH;
    endcase
  end

  always_comb begin
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    ALUOp      = 2'b00;
    ALUSrcB    = 2'b00;
    PCSource   = 2'b00;
    illegal_op = 1'b0;
    // outputs are forced quiet during reset even though the state already reads IFETCH
    if (!rst) begin
      case (state_q)
        S_IFETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = rdy;
          IRWrite = rdy;
        end
        S_ID: begin
          ALUSrcB    = 2'b11;
          illegal_op = !(opcode == OP_RTYPE || opcode == OP_BEQ || opcode == OP_ADDI ||
                         opcode == OP_LW || opcode == OP_SW || opcode == OP_J);
        end
        S_EX_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_WB_R: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_EX_B: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b01;
          Branch   = 1'b1;
          PCSource = 2'b01;
        end
        S_EX_I, S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_WB_I: RegWrite = 1'b1;
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EX_J: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_p.sv
// Bench for mc_control_p: directed and random instruction streams against an
// instruction-level model of state sequences and per-state control values.
module tb_mc_control_p;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, opcode_n;
  logic       mem_ready, mr_n;

  logic       RegDst, ALUSrcA, MemtoReg, RegWrite, MemRead, MemWrite, Branch, PCWrite, IorD, IRWrite;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic       illegal_op;
  logic [3:0] state_dbg;

  logic       n_RegDst, n_ALUSrcA, n_MemtoReg, n_RegWrite, n_MemRead, n_MemWrite, n_Branch, n_PCWrite, n_IorD, n_IRWrite;
  logic [1:0] n_ALUOp, n_ALUSrcB, n_PCSource;
  logic       n_illegal_op;
  logic [3:0] n_state_dbg;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  mc_control_p u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .PCWrite(PCWrite),
    .IorD(IorD), .IRWrite(IRWrite), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  mc_control_p #(.USE_MEM_READY(0)) u_nr (
    .clk(clk), .rst(rst), .opcode(opcode_n), .mem_ready(mr_n),
    .RegDst(n_RegDst), .ALUSrcA(n_ALUSrcA), .MemtoReg(n_MemtoReg), .RegWrite(n_RegWrite),
    .MemRead(n_MemRead), .MemWrite(n_MemWrite), .Branch(n_Branch), .PCWrite(n_PCWrite),
    .IorD(n_IorD), .IRWrite(n_IRWrite), .ALUOp(n_ALUOp), .ALUSrcB(n_ALUSrcB), .PCSource(n_PCSource),
    .illegal_op(n_illegal_op), .state_dbg(n_state_dbg)
  );

  logic [16:0] obs, obs_n;
  assign obs   = {RegDst, ALUSrcA, MemtoReg, RegWrite, MemRead, MemWrite, Branch, PCWrite,
                  IorD, IRWrite, ALUOp, ALUSrcB, PCSource, illegal_op};
  assign obs_n = {n_RegDst, n_ALUSrcA, n_MemtoReg, n_RegWrite, n_MemRead, n_MemWrite, n_Branch, n_PCWrite,
                  n_IorD, n_IRWrite, n_ALUOp, n_ALUSrcB, n_PCSource, n_illegal_op};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
  endfunction

  // Control values the datapath needs in each step of an instruction
  function automatic logic [16:0] exp_out(input int s, input logic [5:0] op, input logic mr);
    logic rd = 0, asa = 0, m2r = 0, rw = 0, mrd = 0, mwr = 0, br = 0, pcw = 0, iord = 0, irw = 0, ill = 0;
    logic [1:0] aop = 0, asb = 0, pcs = 0;
    case (s)
      0:       begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
      1:       begin asb = 2'b11; ill = !is_legal(op); end
      2:       begin asa = 1; aop = 2'b10; end
      3:       begin rd = 1; rw = 1; end
      4:       begin asa = 1; aop = 2'b01; br = 1; pcs = 2'b01; end
      5, 7:    begin asa = 1; asb = 2'b10; end
      6:       rw = 1;
      8:       begin mrd = 1; iord = 1; end
      9:       begin rw = 1; m2r = 1; end
      10:      begin mwr = 1; iord = 1; end
      11:      begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {rd, asa, m2r, rw, mrd, mwr, br, pcw, iord, irw, aop, asb, pcs, ill};
  endfunction

  int   q_st[$];
  logic q_mr[$];

  task automatic push(input int s, input logic mr);
    q_st.push_back(s);
    q_mr.push_back(mr);
  endtask

  // Expected walk of one instruction: waiting states get w cycles of mem_ready=0 then a 1;
  // states that do not care about mem_ready see a random value
  task automatic build(input logic [5:0] op, input int w_if, input int w_mem);
    q_st.delete(); q_mr.delete();
    for (int i = 0; i < w_if; i++) push(0, 1'b0);
    push(0, 1'b1);
    push(1, 1'($urandom));
    case (op)
      6'h00: begin push(2, 1'($urandom)); push(3, 1'($urandom)); end
      6'h08: begin push(5, 1'($urandom)); push(6, 1'($urandom)); end
      6'h04: push(4, 1'($urandom));
      6'h02: push(11, 1'($urandom));
      6'h23: begin
        push(7, 1'($urandom));
        for (int i = 0; i < w_mem; i++) push(8, 1'b0);
        push(8, 1'b1);
        push(9, 1'($urandom));
      end
      6'h2B: begin
        push(7, 1'($urandom));
        for (int i = 0; i < w_mem; i++) push(10, 1'b0);
        push(10, 1'b1);
      end
      default: ;
    endcase
  endtask

  // Steps begin just after a falling edge; checks land mid-low-phase
  task automatic run_dut(input logic [5:0] op, input int w_if, input int w_mem, input string tag);
    build(op, w_if, w_mem);
    for (int i = 0; i < q_st.size(); i++) begin
      opcode = op; mem_ready = q_mr[i];
      #1;
      chk($sformatf("%s.st%0d", tag, i), 32'(state_dbg), 32'(q_st[i]));
      chk($sformatf("%s.out%0d", tag, i), 32'(obs), 32'(exp_out(q_st[i], op, q_mr[i])));
      @(negedge clk);
    end
    #1 chk({tag, ".ret"}, 32'(state_dbg), 32'd0);
  endtask

  logic [5:0] ops[8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h11};

  initial begin
    rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0; opcode_n = 6'h3F; mr_n = 1'b0;
    #3;
    chk("rst.st", 32'(state_dbg), 32'd0);
    chk("rst.out", 32'(obs), 32'd0);
    @(negedge clk); @(negedge clk);
    chk("rst.hold.out", 32'(obs), 32'd0);
    rst = 1'b0;

    run_dut(6'h00, 3, 0, "rtype_ifwait");
    run_dut(6'h23, 0, 2, "lw_wait");
    run_dut(6'h2B, 0, 0, "sw");
    run_dut(6'h3F, 0, 0, "illegal");
    run_dut(6'h02, 0, 0, "jump");
    run_dut(6'h04, 0, 0, "beq");
    run_dut(6'h08, 0, 0, "addi");

    for (int k = 0; k < 40; k++)
      run_dut(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", k));

    // async reset while stalled in MEM_RD
    opcode = 6'h23; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); mem_ready = 1'b0; @(negedge clk);
    #1 chk("arst.pre", 32'(state_dbg), 32'd8);
    #1 rst = 1'b1;
    #1;
    chk("arst.st", 32'(state_dbg), 32'd0);
    chk("arst.out", 32'(obs), 32'd0);
    @(negedge clk);
    chk("arst.hold", 32'(obs), 32'd0);
    rst = 1'b0;
    run_dut(6'h02, 0, 0, "after_rst");

    // build without memory handshake: mem_ready=0 must not stall
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    opcode_n = 6'h23; mr_n = 1'b0;
    begin
      int seq[6] = '{0, 1, 7, 8, 9, 0};
      for (int i = 0; i < 6; i++) begin
        #1;
        chk($sformatf("nr.st%0d", i), 32'(n_state_dbg), 32'(seq[i]));
        chk($sformatf("nr.out%0d", i), 32'(obs_n), 32'(exp_out(seq[i], 6'h23, 1'b1)));
        @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_control_p.md
MC_CONTROL_P -- requirements
Module: mc_control_p

Interface
REQ-001 Parameter OP_W, default 6, opcode field width.
REQ-002 Parameter OP_RTYPE, default 6'h00, R-type opcode.
REQ-003 Parameter OP_LW, default 6'h23; OP_SW, default 6'h2B; OP_BEQ, default 6'h04; OP_ADDI, default 6'h08; OP_J, default 6'h02.
REQ-004 Parameter USE_MEM_READY, default 1; 1 = memory states wait on mem_ready, 0 = mem_ready ignored and treated as 1.
REQ-005 Port list: clk (input, 1, clock); rst (input, 1, reset).
REQ-006 opcode (input, OP_W, instruction opcode); mem_ready (input, 1, memory access complete this cycle).
REQ-007 RegDst, ALUSrcA, MemtoReg, RegWrite, MemRead, MemWrite, Branch, PCWrite, IorD, IRWrite (output, 1 each, datapath controls).
REQ-008 ALUOp, ALUSrcB, PCSource (output, 2 each, datapath selects).
REQ-009 illegal_op (output, 1, one-cycle pulse on an undecoded opcode); state_dbg (output, 4, current state code).
REQ-010 One clock, clk; reset is asynchronous and active-high, named rst.

Function
REQ-011 States SHALL be encoded IFETCH=0, ID=1, EX_R=2, WB_R=3, EX_B=4, EX_I=5, WB_I=6, MEM_ADDR=7, MEM_RD=8, MEM_WB=9, MEM_WR=10, EX_J=11; codes 12-15 SHALL go to IFETCH on the next edge.
REQ-012 IFETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; PCWrite=IRWrite=mem_ready; remain in IFETCH while mem_ready=0, else go to ID.
REQ-013 ID: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by opcode: RTYPE->EX_R, BEQ->EX_B, ADDI->EX_I, LW/SW->MEM_ADDR, J->EX_J, other->IFETCH with illegal_op=1 in this cycle.
REQ-014 EX_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> WB_R.
REQ-015 WB_R: RegDst=1, RegWrite=1, MemtoReg=0; -> IFETCH.
REQ-016 EX_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> WB_I.
REQ-017 WB_I: RegDst=0, RegWrite=1, MemtoReg=0; -> IFETCH.
REQ-018 EX_B: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSource=01; -> IFETCH.
REQ-019 EX_J: PCWrite=1, PCSource=10; -> IFETCH.
REQ-020 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; LW->MEM_RD, SW->MEM_WR (opcode held stable by datapath IR).
REQ-021 MEM_RD: MemRead=1, IorD=1; hold while mem_ready=0, else -> MEM_WB.
REQ-022 MEM_WR: MemWrite=1, IorD=1; hold while mem_ready=0, else -> IFETCH.
REQ-023 MEM_WB: RegDst=0, RegWrite=1, MemtoReg=1; -> IFETCH.
REQ-024 Every output not listed for a state SHALL be 0 in that state; outputs SHALL be combinational from state, opcode and mem_ready only.
REQ-025 Latencies with mem_ready=1: R-type/ADDI/LW(-1 for SW) 4/4/5/4 cycles, BEQ/J 3 cycles; each wait cycle adds exactly one.
REQ-026 state_dbg SHALL equal the state register at all times.

Reset
REQ-027 rst=1 SHALL force the state to IFETCH immediately, independent of clk.
REQ-028 While rst=1 all control outputs and illegal_op SHALL be 0 and state_dbg=0.
REQ-029 Reset asserted mid-instruction (any state, including a memory wait) SHALL abandon it; the first active edge after release SHALL advance from IFETCH per REQ-012.

Verification
REQ-030 rst pulse then opcode=6'h00, mem_ready=1 -> states 0,1,2,3,0; RegWrite=1 and RegDst=1 only in state 3.
REQ-031 opcode=6'h23, mem_ready low 2 cycles in MEM_RD -> states 0,1,7,8,8,8,9,0; MemtoReg=1 only in 9.
REQ-032 opcode=6'h2B, mem_ready=1 -> states 0,1,7,10,0; MemWrite=1 for exactly one cycle.
REQ-033 opcode=6'h3F -> ID shows illegal_op=1 for one cycle, next state 0; opcode=6'h02 -> EX_J with PCWrite=1, PCSource=10.
REQ-034 mem_ready=0 for 3 cycles in IFETCH -> MemRead=1 throughout, PCWrite=IRWrite=0 until the mem_ready=1 cycle.
REQ-035 rst asserted asynchronously in state 8 between edges -> state_dbg=0 and all outputs 0 before the next edge; USE_MEM_READY=0 build ignores mem_ready=0.
